// File: rtl/fetch_prefetch_unit.sv
// fetch_prefetch_unit
//   Instruction-fetch front end. Issues sequential word-aligned fetch
//   addresses to instruction memory, buffers the returned words together with
//   their PCs in a small FIFO and hands them downstream. A redirect flushes the
//   buffer and arranges for every response still in flight to be discarded.
//
// Ports
//   clk, rst_n          clock (rising edge), asynchronous active-low reset
//   redirect_valid/pc   branch/jump target, bits [1:0] of the pc are ignored
//   imem_req_valid/ready, imem_addr          fetch request channel
//   imem_rsp_valid, imem_rsp_data            in-order response channel
//   instr_valid/ready, instr_data, instr_pc  downstream instruction channel
module fetch_prefetch_unit #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          FIFO_DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    output logic        instr_valid,
    input  logic        instr_ready,
    output logic [31:0] instr_data,
    output logic [31:0] instr_pc
);

    localparam int          AW      = $clog2(FIFO_DEPTH);
    localparam int          CW      = AW + 1;
    localparam logic [CW:0] DEPTH_W = (CW + 1)'(FIFO_DEPTH);

    typedef enum logic {ST_BOOT, ST_RUN} state_e;

    state_e        state_q, state_d;
    logic [31:0]   fetch_pc_q, fetch_pc_d;
    logic [CW-1:0] cnt_q, cnt_d;      // FIFO occupancy
    logic [CW-1:0] outst_q, outst_d;  // requests accepted, response not yet seen
    logic [CW-1:0] drop_q, drop_d;    // in-flight responses belonging to a flushed stream
    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [AW-1:0] pcq_wr_q, pcq_rd_q;

    logic [31:0]   data_rd [FIFO_DEPTH];
    logic [31:0]   pc_rd   [FIFO_DEPTH];
    logic [31:0]   pcq_rd  [FIFO_DEPTH];

    logic [CW:0]   credit_sum;
    logic          req_fire, rsp_take, push, pop, flush;

    // Unused low target bits are dropped on purpose (word alignment).
    logic          unused_pc_bits;
    assign unused_pc_bits = ^redirect_pc[1:0];

    // Every outstanding request owns a FIFO slot, so a response can always be
    // pushed without overflow and without back-pressuring memory.
    assign credit_sum     = {1'b0, cnt_q} + {1'b0, outst_q};
    assign imem_req_valid = (state_q == ST_RUN) && (credit_sum < DEPTH_W);
    assign imem_addr      = fetch_pc_q;
    assign req_fire       = imem_req_valid && imem_req_ready;
    // A response with nothing outstanding is ignored so the counters cannot underflow.
    assign rsp_take       = imem_rsp_valid && (outst_q != '0);
    assign flush          = redirect_valid;
    assign push           = rsp_take && (drop_q == '0) && !flush;
    assign instr_valid    = (cnt_q != '0);
    assign pop            = instr_valid && instr_ready;
    assign instr_data     = data_rd[rd_ptr_q];
    assign instr_pc       = pc_rd[rd_ptr_q];

    always_comb begin
        state_d    = ST_RUN;
        fetch_pc_d = fetch_pc_q;
        outst_d    = outst_q;
        drop_d     = drop_q;
        cnt_d      = cnt_q;

        if (req_fire && !rsp_take) begin
            outst_d = outst_q + 1'b1;
        end else if (!req_fire && rsp_take) begin
            outst_d = outst_q - 1'b1;
        end

        if (req_fire) begin
            fetch_pc_d = fetch_pc_q + 32'd4;
        end

        if (rsp_take && (drop_q != '0)) begin
            drop_d = drop_q - 1'b1;
        end

        if (push && !pop) begin
            cnt_d = cnt_q + 1'b1;
        end else if (!push && pop) begin
            cnt_d = cnt_q - 1'b1;
        end

        // Everything still outstanding after this cycle belongs to the old
        // stream, including a request accepted right now; a response arriving
        // now has already been excluded from outst_d and is not pushed.
        if (flush) begin
            fetch_pc_d = {redirect_pc[31:2], 2'b00};
            drop_d     = outst_d;
            cnt_d      = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_BOOT;
            fetch_pc_q <= RESET_PC;
            cnt_q      <= '0;
            outst_q    <= '0;
            drop_q     <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            pcq_wr_q   <= '0;
            pcq_rd_q   <= '0;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            cnt_q      <= cnt_d;
            outst_q    <= outst_d;
            drop_q     <= drop_d;
            if (flush) begin
                wr_ptr_q <= '0;
                rd_ptr_q <= '0;
                pcq_wr_q <= '0;
                pcq_rd_q <= '0;
            end else begin
                if (push)     wr_ptr_q <= wr_ptr_q + 1'b1;
                if (pop)      rd_ptr_q <= rd_ptr_q + 1'b1;
                if (req_fire) pcq_wr_q <= pcq_wr_q + 1'b1;
                if (push)     pcq_rd_q <= pcq_rd_q + 1'b1;
            end
        end
    end

    // Storage entries. The PC queue only holds PCs of requests that will be
    // kept; dropped responses never touch it because it is emptied on flush.
    for (genvar gi = 0; gi < FIFO_DEPTH; gi++) begin : g_entry
        logic [31:0] data_q;
        logic [31:0] pc_q;
        logic [31:0] pcq_q;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                data_q <= '0;
                pc_q   <= '0;
                pcq_q  <= '0;
            end else begin
                if (push && (wr_ptr_q == AW'(gi))) begin
                    data_q <= imem_rsp_data;
                    pc_q   <= pcq_rd[pcq_rd_q];
                end
                if (req_fire && !flush && (pcq_wr_q == AW'(gi))) begin
                    pcq_q <= fetch_pc_q;
                end
            end
        end

        assign data_rd[gi] = data_q;
        assign pc_rd[gi]   = pc_q;
        assign pcq_rd[gi]  = pcq_q;
    end

endmodule

// File: tb/tb_fetch_prefetch_unit.sv
// Testbench for fetch_prefetch_unit: directed scenarios plus a randomized
// run, with an in-order memory model and a sequential-PC scoreboard.
module tb_fetch_prefetch_unit;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam int          DEPTH    = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] instr_data;
    logic [31:0] instr_pc;

    fetch_prefetch_unit #(.RESET_PC(RESET_PC), .FIFO_DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
        .imem_addr(imem_addr),
        .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
        .instr_valid(instr_valid), .instr_ready(instr_ready),
        .instr_data(instr_data), .instr_pc(instr_pc)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        int          due;
    } req_t;

    req_t        mq[$];          // accepted requests awaiting response
    logic [31:0] pop_log[$];     // PCs seen at the output, in order
    int          n_vec = 0;
    int          n_err = 0;
    int          cyc = 0;
    int          lat_min = 1;
    int          lat_max = 1;
    int          acc_count = 0;
    int          pop_count = 0;
    logic [31:0] last_acc_addr = '0;
    logic [31:0] exp_pc = RESET_PC;
    bit          verbose = 1'b1;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
    endfunction

    // One clock cycle: capture handshakes before the edge, then update the
    // memory model and the scoreboard on the falling edge.
    task automatic tick();
        logic        acc, pop, rsp, redir, iv_stall, rq_stall;
        logic [31:0] a, ppc, pdata, raddr;
        int          d;
        acc      = imem_req_valid & imem_req_ready;
        a        = imem_addr;
        pop      = instr_valid & instr_ready;
        ppc      = instr_pc;
        pdata    = instr_data;
        rsp      = imem_rsp_valid;
        redir    = redirect_valid;
        raddr    = redirect_pc;
        iv_stall = instr_valid & ~instr_ready & ~redir;
        rq_stall = imem_req_valid & ~imem_req_ready & ~redir;
        @(posedge clk);
        @(negedge clk);
        cyc++;
        if (pop) begin
            n_vec++;
            if (ppc !== exp_pc || pdata !== mem_word(exp_pc)) begin
                n_err++;
                $display("FAIL scoreboard: got pc=%h data=%h, expected pc=%h data=%h",
                         ppc, pdata, exp_pc, mem_word(exp_pc));
            end else if (verbose) begin
                $display("instr pc=%h data=%h", ppc, pdata);
            end
            pop_count++;
            pop_log.push_back(ppc);
            exp_pc = exp_pc + 32'd4;
        end
        if (redir) exp_pc = {raddr[31:2], 2'b00};
        if (rsp && mq.size() > 0) void'(mq.pop_front());
        if (acc) begin
            d = cyc + int'($urandom_range(lat_max, lat_min)) - 1;
            mq.push_back('{addr: a, due: d});
            acc_count++;
            last_acc_addr = a;
        end
        n_vec++;
        if (mq.size() > DEPTH) begin
            n_err++;
            $display("FAIL credit: %0d requests in flight, limit %0d", mq.size(), DEPTH);
        end
        if (iv_stall) begin
            n_vec++;
            if (instr_valid !== 1'b1 || instr_pc !== ppc || instr_data !== pdata) begin
                n_err++;
                $display("FAIL out_stable: got v=%b pc=%h data=%h, expected v=1 pc=%h data=%h",
                         instr_valid, instr_pc, instr_data, ppc, pdata);
            end
        end
        if (rq_stall) begin
            n_vec++;
            if (imem_req_valid !== 1'b1 || imem_addr !== a) begin
                n_err++;
                $display("FAIL req_stable: got v=%b addr=%h, expected v=1 addr=%h",
                         imem_req_valid, imem_addr, a);
            end
        end
        if (mq.size() > 0 && mq[0].due <= cyc) begin
            imem_rsp_valid = 1'b1;
            imem_rsp_data  = mem_word(mq[0].addr);
        end else begin
            imem_rsp_valid = 1'b0;
            imem_rsp_data  = '0;
        end
    endtask

    task automatic apply_reset();
        rst_n          = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        imem_req_ready = 1'b0;
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = '0;
        instr_ready    = 1'b0;
        mq.delete();
        pop_log.delete();
        pop_count = 0;
        acc_count = 0;
        cyc       = 0;
        exp_pc    = RESET_PC;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic do_redirect(input logic [31:0] target);
        redirect_valid = 1'b1;
        redirect_pc    = target;
        tick();
        redirect_valid = 1'b0;
    endtask

    task automatic wait_pops(input int target, input string name);
        for (int i = 0; i < 60 && pop_count < target; i++) tick();
        n_vec++;
        if (pop_count < target) begin
            n_err++;
            $display("FAIL %s_timeout: got %0d outputs, expected %0d", name, pop_count, target);
        end
    endtask

    task automatic test_reset();
        apply_reset();
        rst_n = 1'b0;
        #1;
        n_vec++;
        if ({imem_req_valid, instr_valid} !== 2'b00 || instr_data !== '0 || instr_pc !== '0) begin
            n_err++;
            $display("FAIL reset_outputs: got rv=%b iv=%b data=%h pc=%h, expected all zero",
                     imem_req_valid, instr_valid, instr_data, instr_pc);
        end
        @(negedge clk);
        rst_n = 1'b1;
        n_vec++;
        if (imem_req_valid !== 1'b0) begin
            n_err++;
            $display("FAIL boot_no_req: got %b expected 0", imem_req_valid);
        end
        tick();
        n_vec++;
        if (imem_req_valid !== 1'b1 || imem_addr !== RESET_PC) begin
            n_err++;
            $display("FAIL first_req: got v=%b addr=%h, expected v=1 addr=%h",
                     imem_req_valid, imem_addr, RESET_PC);
        end
    endtask

    task automatic test_sequential();
        apply_reset();
        imem_req_ready = 1'b1;
        instr_ready    = 1'b1;
        lat_min = 1; lat_max = 1;
        tick();
        tick();
        n_vec++;
        if (instr_valid !== 1'b0) begin
            n_err++;
            $display("FAIL early_valid: got %b expected 0 two cycles after release", instr_valid);
        end
        tick();
        n_vec++;
        if (instr_valid !== 1'b1 || instr_pc !== 32'h0 || instr_data !== mem_word(32'h0)) begin
            n_err++;
            $display("FAIL first_valid: got v=%b pc=%h data=%h, expected v=1 pc=0 data=%h",
                     instr_valid, instr_pc, instr_data, mem_word(32'h0));
        end
        wait_pops(3, "seq");
        n_vec++;
        if (pop_count >= 3 && (pop_log[0] !== 32'h0 || pop_log[1] !== 32'h4 || pop_log[2] !== 32'h8)) begin
            n_err++;
            $display("FAIL seq_order: got %h %h %h expected 0 4 8", pop_log[0], pop_log[1], pop_log[2]);
        end
    endtask

    task automatic test_backpressure();
        int base;
        apply_reset();
        imem_req_ready = 1'b1;
        instr_ready    = 1'b0;
        lat_min = 1; lat_max = 1;
        repeat (12) tick();
        n_vec++;
        if (acc_count !== DEPTH || imem_req_valid !== 1'b0) begin
            n_err++;
            $display("FAIL bp_credit: got %0d requests, req_valid=%b, expected %0d and 0",
                     acc_count, imem_req_valid, DEPTH);
        end
        n_vec++;
        if (instr_valid !== 1'b1 || instr_pc !== 32'h0 || instr_data !== mem_word(32'h0)) begin
            n_err++;
            $display("FAIL bp_head: got v=%b pc=%h data=%h, expected v=1 pc=0 data=%h",
                     instr_valid, instr_pc, instr_data, mem_word(32'h0));
        end
        instr_ready = 1'b1;
        base = acc_count;
        for (int i = 0; i < 20 && acc_count == base; i++) tick();
        n_vec++;
        if (acc_count == base || last_acc_addr !== 32'h10) begin
            n_err++;
            $display("FAIL bp_resume: got addr=%h expected 00000010", last_acc_addr);
        end
        wait_pops(4, "bp");
        n_vec++;
        if (pop_count >= 4 && (pop_log[0] !== 32'h0 || pop_log[3] !== 32'hC)) begin
            n_err++;
            $display("FAIL bp_drain: got first=%h fourth=%h expected 0 and c", pop_log[0], pop_log[3]);
        end
    endtask

    task automatic test_redirect();
        apply_reset();
        imem_req_ready = 1'b1;
        instr_ready    = 1'b1;
        lat_min = 3; lat_max = 3;
        repeat (3) tick();
        n_vec++;
        if (mq.size() != 2) begin
            n_err++;
            $display("FAIL rd_setup: got %0d outstanding expected 2", mq.size());
        end
        imem_req_ready = 1'b0;
        do_redirect(32'h0000_1003);
        n_vec++;
        if (imem_req_valid !== 1'b1 || imem_addr !== 32'h0000_1000) begin
            n_err++;
            $display("FAIL rd_addr: got v=%b addr=%h expected v=1 addr=00001000",
                     imem_req_valid, imem_addr);
        end
        imem_req_ready = 1'b1;
        wait_pops(1, "rd");
        n_vec++;
        if (pop_count >= 1 && pop_log[0] !== 32'h0000_1000) begin
            n_err++;
            $display("FAIL rd_first_pc: got %h expected 00001000", pop_log[0]);
        end
    endtask

    task automatic test_collision();
        int base;
        apply_reset();
        imem_req_ready = 1'b1;
        instr_ready    = 1'b1;
        lat_min = 1; lat_max = 1;
        repeat (6) tick();
        n_vec++;
        if (instr_valid !== 1'b1 || imem_rsp_valid !== 1'b1) begin
            n_err++;
            $display("FAIL col_setup: got iv=%b rsp=%b expected both 1", instr_valid, imem_rsp_valid);
        end
        do_redirect(32'h0000_2000);
        base = pop_count;
        n_vec++;
        if (instr_valid !== 1'b0) begin
            n_err++;
            $display("FAIL col_flush: got instr_valid=%b expected 0", instr_valid);
        end
        wait_pops(base + 1, "col");
        n_vec++;
        if (pop_count > base && pop_log[base] !== 32'h0000_2000) begin
            n_err++;
            $display("FAIL col_first_pc: got %h expected 00002000", pop_log[base]);
        end
    endtask

    task automatic test_wrap();
        int base;
        apply_reset();
        imem_req_ready = 1'b1;
        instr_ready    = 1'b1;
        lat_min = 1; lat_max = 2;
        repeat (5) tick();
        do_redirect(32'hFFFF_FFF8);
        base = pop_count;
        wait_pops(base + 3, "wrap");
        n_vec++;
        if (pop_count >= base + 3 && (pop_log[base] !== 32'hFFFF_FFF8 ||
            pop_log[base+1] !== 32'hFFFF_FFFC || pop_log[base+2] !== 32'h0)) begin
            n_err++;
            $display("FAIL wrap_seq: got %h %h %h expected fffffff8 fffffffc 00000000",
                     pop_log[base], pop_log[base+1], pop_log[base+2]);
        end
    endtask

    task automatic random_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            imem_req_ready = ($urandom_range(3, 0) != 0);
            instr_ready    = ($urandom_range(2, 0) != 0);
            if ($urandom_range(99, 0) < 3) begin
                redirect_valid = 1'b1;
                redirect_pc    = $urandom;
            end else begin
                redirect_valid = 1'b0;
            end
            tick();
        end
        redirect_valid = 1'b0;
    endtask

    task automatic test_random();
        int base;
        apply_reset();
        lat_min = 1; lat_max = 3;
        verbose = 1'b0;
        random_cycles(1500);
        n_vec++;
        if (pop_count < 200) begin
            n_err++;
            $display("FAIL rand_progress: got %0d outputs expected at least 200", pop_count);
        end
        // Reset mid-operation, away from the clock edge: outputs must clear at once.
        #2;
        rst_n = 1'b0;
        #1;
        n_vec++;
        if ({imem_req_valid, instr_valid} !== 2'b00 || instr_data !== '0 || instr_pc !== '0) begin
            n_err++;
            $display("FAIL async_reset: got rv=%b iv=%b data=%h pc=%h, expected all zero",
                     imem_req_valid, instr_valid, instr_data, instr_pc);
        end
        mq.delete();
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = '0;
        exp_pc         = RESET_PC;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        base = pop_count;
        instr_ready    = 1'b1;
        imem_req_ready = 1'b1;
        wait_pops(base + 1, "post_reset");
        n_vec++;
        if (pop_count > base && pop_log[base] !== RESET_PC) begin
            n_err++;
            $display("FAIL post_reset_pc: got %h expected %h", pop_log[base], RESET_PC);
        end
        random_cycles(400);
    endtask

    initial begin
        test_reset();
        test_sequential();
        test_backpressure();
        test_redirect();
        test_collision();
        test_wrap();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
